// File: rtl/lut1_probe_checker.sv
// On-fabric stimulus/response checker for a single-input LUT: sweeps I=0/1,
// samples O through a 2-flop synchronizer, and reports an error count and pass flag.
module lut1_probe_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [1:0]  LUT_INIT      = 2'b01,
  parameter int unsigned NUM_ROUNDS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       probe_i,
  input  logic       probe_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       first_fail_in
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("lut1_probe_checker: SETTLE_CYCLES must be in 1..255");
  end
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 255) begin : g_bad_rounds
    $error("lut1_probe_checker: NUM_ROUNDS must be in 1..255");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  // Settle reload includes the two synchronizer cycles, so it needs a ninth bit
  // to hold SETTLE_CYCLES=255.
  localparam logic [8:0] SETTLE_LOAD = 9'(SETTLE_CYCLES + 2);
  localparam logic [8:0] ROUNDS_LAST = 9'(NUM_ROUNDS);

  state_e     state_q, state_d;
  logic       phase_q, phase_d;
  logic [7:0] round_q, round_d;
  logic [8:0] cnt_q, cnt_d;
  logic       probe_i_q, probe_i_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] err_q, err_d;
  logic       ffi_q, ffi_d;
  logic       s1_q, s2_q;
  logic       mismatch;

  assign mismatch = (s2_q != LUT_INIT[phase_q]);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    round_d   = round_q;
    cnt_d     = cnt_q;
    probe_i_d = probe_i_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    ffi_d     = ffi_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          err_d   = 8'd0;
          ffi_d   = 1'b0;
          round_d = 8'd0;
          phase_d = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_DRIVE: begin
        probe_i_d = phase_q;
        cnt_d     = SETTLE_LOAD;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == 9'd1) state_d = ST_SAMPLE;
        else               cnt_d   = cnt_q - 9'd1;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          // err_q is still zero only before the first mismatch of the run.
          if (err_q == 8'd0)  ffi_d = phase_q;
        end
        if (!phase_q) begin
          phase_d = 1'b1;
          state_d = ST_DRIVE;
        end else begin
          phase_d = 1'b0;
          round_d = round_q + 8'd1;
          if (({1'b0, round_q} + 9'd1) == ROUNDS_LAST) begin
            state_d   = ST_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            probe_i_d = 1'b0;
            pass_d    = (err_d == 8'd0);
          end else begin
            state_d = ST_DRIVE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so all
  // flops sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      round_q   <= 8'd0;
      cnt_q     <= 9'd0;
      probe_i_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 8'd0;
      ffi_q     <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      round_q   <= round_d;
      cnt_q     <= cnt_d;
      probe_i_q <= probe_i_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ffi_q     <= ffi_d;
      s1_q      <= probe_o;
      s2_q      <= s1_q;
    end
  end

  assign probe_i       = probe_i_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_fail_in = ffi_q;

endmodule

// File: tb/tb_lut1_probe_checker.sv
// Self-checking bench: four checker instances with different parameters, each
// wired to a behavioural LUT model, compared against a truth-table reference.
module tb_lut1_probe_checker;

  localparam logic [1:0] LUT_P    [4] = '{2'b01, 2'b10, 2'b01, 2'b11};
  localparam int         SETTLE_P [4] = '{4, 4, 1, 4};
  localparam int         ROUNDS_P [4] = '{8, 8, 8, 255};

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v   [4];
  logic       probe_i_v [4];
  logic       probe_o_v [4];
  logic       busy_v    [4];
  logic       done_v    [4];
  logic       pass_v    [4];
  logic [7:0] err_v     [4];
  logic       ffi_v     [4];

  logic [1:0] tbl     [4];
  logic       use_dly [4];
  logic [2:0] dly     [4];

  int n_total = 0;
  int n_pass  = 0;
  logic busy_ok;

  always #5 clk = ~clk;

  // LUT models: truth table lookup, or an inverter behind three registers.
  for (genvar g = 0; g < 4; g++) begin : g_model
    always @(posedge clk or posedge rst) begin
      if (rst) dly[g] <= 3'b000;
      else     dly[g] <= {dly[g][1:0], probe_i_v[g]};
    end
    assign probe_o_v[g] = use_dly[g] ? ~dly[g][2] : tbl[g][probe_i_v[g]];
  end

  lut1_probe_checker #(.SETTLE_CYCLES(SETTLE_P[0]), .LUT_INIT(LUT_P[0]), .NUM_ROUNDS(ROUNDS_P[0])) u_dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .probe_i(probe_i_v[0]), .probe_o(probe_o_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]), .first_fail_in(ffi_v[0]));
  lut1_probe_checker #(.SETTLE_CYCLES(SETTLE_P[1]), .LUT_INIT(LUT_P[1]), .NUM_ROUNDS(ROUNDS_P[1])) u_buf (
    .clk(clk), .rst(rst), .start(start_v[1]), .probe_i(probe_i_v[1]), .probe_o(probe_o_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]), .first_fail_in(ffi_v[1]));
  lut1_probe_checker #(.SETTLE_CYCLES(SETTLE_P[2]), .LUT_INIT(LUT_P[2]), .NUM_ROUNDS(ROUNDS_P[2])) u_s1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .probe_i(probe_i_v[2]), .probe_o(probe_o_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]), .first_fail_in(ffi_v[2]));
  lut1_probe_checker #(.SETTLE_CYCLES(SETTLE_P[3]), .LUT_INIT(LUT_P[3]), .NUM_ROUNDS(ROUNDS_P[3])) u_big (
    .clk(clk), .rst(rst), .start(start_v[3]), .probe_i(probe_i_v[3]), .probe_o(probe_o_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_count(err_v[3]), .first_fail_in(ffi_v[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int latency(input int i);
    return ROUNDS_P[i] * 2 * (SETTLE_P[i] + 4);
  endfunction

  // Reference: each round compares both table entries; mismatching entries
  // add one error per round, clipped at 255; phase 0 is probed first.
  function automatic void ref_model(input int i, input logic [1:0] act,
                                    output int err, output logic ffi);
    logic [1:0] diff;
    diff = act ^ LUT_P[i];
    err  = (int'(diff[0]) + int'(diff[1])) * ROUNDS_P[i];
    if (err > 255) err = 255;
    ffi  = diff[0] ? 1'b0 : diff[1];
  endfunction

  // Start a run on instance i and wait (bounded) for done; optionally pulse
  // start again while busy at cycle pulse_at.
  task automatic do_run(input int i, input int pulse_at, output int cyc);
    int budget;
    budget = latency(i) + 64;
    @(negedge clk); start_v[i] = 1'b1;
    @(posedge clk); #1; start_v[i] = 1'b0;
    cyc = 0;
    busy_ok = busy_v[i];
    while (!done_v[i] && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      start_v[i] = (cyc == pulse_at);
      if (!done_v[i]) busy_ok &= busy_v[i];
    end
    start_v[i] = 1'b0;
  endtask

  task automatic check_run(input string tag, input int i, input logic [1:0] act, input int pulse_at);
    int   cyc, exp_err;
    logic exp_ffi;
    tbl[i]     = act;
    use_dly[i] = 1'b0;
    ref_model(i, act, exp_err, exp_ffi);
    do_run(i, pulse_at, cyc);
    check({tag, "_latency"}, cyc, latency(i));
    check({tag, "_busy_run"}, busy_ok, 1'b1);
    check({tag, "_busy_end"}, busy_v[i], 1'b0);
    check({tag, "_err"}, err_v[i], exp_err);
    check({tag, "_pass"}, pass_v[i], exp_err == 0);
    check({tag, "_ffi"}, ffi_v[i], exp_ffi);
    check({tag, "_probe_i"}, probe_i_v[i], 1'b0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      tbl[i]     = 2'b01;
      use_dly[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_v[0], 1'b0);
    check("rst_done", done_v[0], 1'b0);
    check("rst_pass", pass_v[0], 1'b0);
    check("rst_err", err_v[0], 8'd0);
    check("rst_ffi", ffi_v[0], 1'b0);
    check("rst_probe_i", probe_i_v[0], 1'b0);
    @(negedge clk); rst = 1'b0;

    check_run("inverter", 0, 2'b01, -1);
    check_run("stuck1", 0, 2'b11, -1);
    check_run("buf_lut10", 1, 2'b10, -1);
    check_run("buf_lut01", 0, 2'b10, -1);

    // Inverter behind three registers: too short a settle sees stale data.
    use_dly[2] = 1'b1;
    do_run(2, -1, cyc);
    check("dly_s1_done", done_v[2], 1'b1);
    check("dly_s1_err_nonzero", err_v[2] != 8'd0, 1'b1);
    check("dly_s1_pass", pass_v[2], 1'b0);
    use_dly[0] = 1'b1;
    do_run(0, -1, cyc);
    check("dly_s4_latency", cyc, latency(0));
    check("dly_s4_err", err_v[0], 8'd0);
    check("dly_s4_pass", pass_v[0], 1'b1);
    use_dly[0] = 1'b0;

    // Reset 40 cycles into a failing run clears everything within the cycle.
    tbl[0] = 2'b11;
    @(negedge clk); start_v[0] = 1'b1;
    @(posedge clk); #1; start_v[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("mid_busy_before", busy_v[0], 1'b1);
    check("mid_err_before_nonzero", err_v[0] != 8'd0, 1'b1);
    #1; rst = 1'b1;
    #1;
    check("mid_rst_busy", busy_v[0], 1'b0);
    check("mid_rst_probe_i", probe_i_v[0], 1'b0);
    check("mid_rst_err", err_v[0], 8'd0);
    check("mid_rst_done", done_v[0], 1'b0);
    @(negedge clk); rst = 1'b0;
    check_run("after_rst", 0, 2'b01, -1);

    for (int k = 0; k < 8; k++) begin
      int         i;
      logic [1:0] act;
      i   = int'($urandom_range(0, 1));
      act = 2'($urandom_range(0, 3));
      check_run($sformatf("rand%0d", k), i, act, -1);
    end

    // A start pulse while busy must not restart the run.
    check_run("start_busy", 0, 2'b01, 50);

    // start held through DONE: the next edge launches a fresh run.
    tbl[0] = 2'b11;
    @(negedge clk); start_v[0] = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!done_v[0] && cyc < latency(0) + 64) begin
      @(posedge clk); #1; cyc++;
    end
    check("b2b_first_latency", cyc, latency(0));
    check("b2b_first_err", err_v[0], 8'd8);
    @(posedge clk); #1;
    check("b2b_restart_done", done_v[0], 1'b0);
    check("b2b_restart_busy", busy_v[0], 1'b1);
    check("b2b_restart_err", err_v[0], 8'd0);
    start_v[0] = 1'b0;
    cyc = 0;
    while (!done_v[0] && cyc < latency(0) + 64) begin
      @(posedge clk); #1; cyc++;
    end
    check("b2b_second_latency", cyc, latency(0));
    check("b2b_second_err", err_v[0], 8'd8);
    check("b2b_second_ffi", ffi_v[0], 1'b1);

    // 255 rounds, both entries wrong: 510 mismatches saturate at 255.
    check_run("saturate", 3, 2'b00, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
